// File: rtl/aes_key_expand_128_inv.sv
// Decrypt-direction AES-128 key scheduler: expands the cipher key forward to round 10,
// then streams round keys 10..0 by inverse expansion. Round-10 key is kept for replay.
module aes_key_expand_128_inv (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_vld,
    output logic         key_rdy,
    input  logic [127:0] key,
    input  logic         replay,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StExpand, StEmit, StReady} state_e;

    state_e       state_q;
    logic [127:0] work_q;
    logic [127:0] k10_q;
    logic [3:0]   cnt_q;
    logic [3:0]   rk_round_q;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0]  w0, w1, w2, w3, w3_inv;
    logic [31:0]  sub_in, rot, sub_rot, rc_word;
    logic [127:0] fwd_next, inv_next;

    assign w0     = work_q[127:96];
    assign w1     = work_q[95:64];
    assign w2     = work_q[63:32];
    assign w3     = work_q[31:0];
    assign w3_inv = w3 ^ w2;

    // One SubRot unit serves both directions: forward uses w3, inverse uses the new w3.
    assign sub_in  = (state_q == StExpand) ? w3 : w3_inv;
    assign rot     = {sub_in[23:0], sub_in[31:24]};
    assign rc_word = {rcon((state_q == StExpand) ? cnt_q : rk_round_q), 24'h000000};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub_rot[8*i +: 8] = aes_sbox(rot[8*i +: 8]);
    end

    logic [31:0] f0, f1, f2, f3;
    assign f0       = w0 ^ sub_rot ^ rc_word;
    assign f1       = w1 ^ f0;
    assign f2       = w2 ^ f1;
    assign f3       = w3 ^ f2;
    assign fwd_next = {f0, f1, f2, f3};
    assign inv_next = {w0 ^ sub_rot ^ rc_word, w1 ^ w0, w2 ^ w1, w3_inv};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            work_q     <= '0;
            k10_q      <= '0;
            cnt_q      <= '0;
            rk_round_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (key_vld) begin
                        work_q  <= key;
                        cnt_q   <= 4'd1;
                        state_q <= StExpand;
                    end
                end
                StExpand: begin
                    work_q <= fwd_next;
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == 4'd10) begin
                        k10_q      <= fwd_next;
                        rk_round_q <= 4'd10;
                        state_q    <= StEmit;
                    end
                end
                StEmit: begin
                    if (out_rdy) begin
                        if (rk_round_q == 4'd0) begin
                            state_q <= StReady;
                        end else begin
                            work_q     <= inv_next;
                            rk_round_q <= rk_round_q - 4'd1;
                        end
                    end
                end
                StReady: begin
                    // A new key takes priority over a simultaneous replay.
                    if (key_vld) begin
                        work_q  <= key;
                        cnt_q   <= 4'd1;
                        state_q <= StExpand;
                    end else if (replay) begin
                        work_q     <= k10_q;
                        rk_round_q <= 4'd10;
                        state_q    <= StEmit;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign key_rdy  = (state_q == StIdle) || (state_q == StReady);
    assign out_vld  = (state_q == StEmit);
    assign busy     = (state_q == StExpand) || (state_q == StEmit);
    assign rk       = work_q;
    assign rk_round = rk_round_q;
    assign rk_last  = out_vld && (rk_round_q == 4'd0);

endmodule
